// File: rtl/stage_decode_if.sv
// stage_decode_if: bundles the decode stage's upstream inputs, writeback
// port, hazard hold request and D/E register outputs.
//
// Handshake: in_valid qualifies in_ins/in_next_pc. The stage consumes the
// FD word on every rising clk edge unless fd_hold is high. While fd_hold is
// high, the upstream FD register must present the same word again on the
// next cycle. flush kills the word entering DE. de_stall freezes DE.
//
// Modports:
//   master - upstream/control side (drives inputs, observes DE outputs)
//   slave  - stage_decode itself
interface stage_decode_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic [31:0]     in_ins;
  logic [XLEN-1:0] in_next_pc;
  logic            flush;
  logic            de_stall;
  logic            wb_wren;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] wb_data;
  logic            fd_hold;
  logic            de_valid;
  logic [XLEN-1:0] de_next_pc;
  logic [5:0]      de_opcode;
  logic [4:0]      de_rs;
  logic [4:0]      de_rt;
  logic [4:0]      de_dest;
  logic [XLEN-1:0] de_rs_data;
  logic [XLEN-1:0] de_rt_data;
  logic [XLEN-1:0] de_imm;
  logic            de_mem_read;
  logic            de_mem_write;
  logic            de_reg_write;
  logic            de_branch;
  logic            de_illegal;

  modport master (
    output in_valid, in_ins, in_next_pc, flush, de_stall,
           wb_wren, wb_addr, wb_data,
    input  fd_hold, de_valid, de_next_pc, de_opcode, de_rs, de_rt, de_dest,
           de_rs_data, de_rt_data, de_imm, de_mem_read, de_mem_write,
           de_reg_write, de_branch, de_illegal
  );

  modport slave (
    input  in_valid, in_ins, in_next_pc, flush, de_stall,
           wb_wren, wb_addr, wb_data,
    output fd_hold, de_valid, de_next_pc, de_opcode, de_rs, de_rt, de_dest,
           de_rs_data, de_rt_data, de_imm, de_mem_read, de_mem_write,
           de_reg_write, de_branch, de_illegal
  );
endinterface

// File: rtl/stage_decode.sv
// stage_decode: instruction decode, 32x32 register file with write-through
// bypass, load-use hazard detection and the D/E pipeline register.
//
// Ports:
//   clk     - system clock, rising edge
//   reset_n - asynchronous active-low reset (DE register only; the register
//             file is not reset)
//   bus     - stage_decode_if.slave: FD inputs, flush/de_stall, writeback
//             port, fd_hold request and all de_* outputs
module stage_decode #(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  stage_decode_if.slave bus
);

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] next_pc;
    logic [5:0]      opcode;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      dest;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic [XLEN-1:0] imm;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            branch;
    logic            illegal;
  } de_t;

  logic [XLEN-1:0] rf_q [NREG];
  de_t             de_q, de_d;

  logic [5:0]      opcode;
  logic [4:0]      rs, rt, rd;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] rs_data, rt_data;
  logic            dec_reg_write, dec_mem_read, dec_mem_write;
  logic            dec_branch, dec_illegal;
  logic [4:0]      dec_dest;
  logic            lu;

  assign opcode  = bus.in_ins[31:26];
  assign rs      = bus.in_ins[25:21];
  assign rt      = bus.in_ins[20:16];
  assign rd      = bus.in_ins[15:11];
  assign imm_ext = {{(XLEN-16){bus.in_ins[15]}}, bus.in_ins[15:0]};

  // Register file write port; r0 is never written so it always reads zero.
  always_ff @(posedge clk) begin
    if (bus.wb_wren && bus.wb_addr != 5'd0) begin
      rf_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Read ports forward same-cycle writeback data so the value written this
  // cycle is captured into DE without waiting for the array update.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (rs != 5'd0) begin
      rs_data = (bus.wb_wren && bus.wb_addr == rs) ? bus.wb_data : rf_q[rs];
    end
    if (rt != 5'd0) begin
      rt_data = (bus.wb_wren && bus.wb_addr == rt) ? bus.wb_data : rf_q[rt];
    end
  end

  always_comb begin
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_branch    = 1'b0;
    dec_illegal   = 1'b0;
    dec_dest      = 5'd0;
    case (opcode)
      6'h00: begin dec_reg_write = 1'b1; dec_dest = rd; end
      6'h08: begin dec_reg_write = 1'b1; dec_dest = rt; end
      6'h23: begin dec_reg_write = 1'b1; dec_mem_read = 1'b1; dec_dest = rt; end
      6'h2B: dec_mem_write = 1'b1;
      6'h04: dec_branch    = 1'b1;
      default: dec_illegal = 1'b1;
    endcase
    // A write to r0 is architecturally a no-op, so never request it.
    if (dec_dest == 5'd0) dec_reg_write = 1'b0;
  end

  // Load in DE whose result the FD instruction needs: hold FD one cycle.
  assign lu = de_q.valid && de_q.mem_read && (de_q.dest != 5'd0) &&
              bus.in_valid && (de_q.dest == rs || de_q.dest == rt);

  assign bus.fd_hold = lu || bus.de_stall;

  always_comb begin
    de_d = de_q;
    if (bus.flush || (!bus.de_stall && lu)) begin
      // Kill (flush) or bubble (load-use): controls cleared, data held.
      de_d.valid     = 1'b0;
      de_d.mem_read  = 1'b0;
      de_d.mem_write = 1'b0;
      de_d.reg_write = 1'b0;
      de_d.branch    = 1'b0;
      de_d.illegal   = 1'b0;
    end else if (!bus.de_stall) begin
      de_d.valid     = bus.in_valid;
      de_d.next_pc   = bus.in_next_pc;
      de_d.opcode    = opcode;
      de_d.rs        = rs;
      de_d.rt        = rt;
      de_d.dest      = dec_dest;
      de_d.rs_data   = rs_data;
      de_d.rt_data   = rt_data;
      de_d.imm       = imm_ext;
      de_d.mem_read  = bus.in_valid && dec_mem_read;
      de_d.mem_write = bus.in_valid && dec_mem_write;
      de_d.reg_write = bus.in_valid && dec_reg_write;
      de_d.branch    = bus.in_valid && dec_branch;
      de_d.illegal   = bus.in_valid && dec_illegal;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      de_q <= '0;
    end else begin
      de_q <= de_d;
    end
  end

  assign bus.de_valid     = de_q.valid;
  assign bus.de_next_pc   = de_q.next_pc;
  assign bus.de_opcode    = de_q.opcode;
  assign bus.de_rs        = de_q.rs;
  assign bus.de_rt        = de_q.rt;
  assign bus.de_dest      = de_q.dest;
  assign bus.de_rs_data   = de_q.rs_data;
  assign bus.de_rt_data   = de_q.rt_data;
  assign bus.de_imm       = de_q.imm;
  assign bus.de_mem_read  = de_q.mem_read;
  assign bus.de_mem_write = de_q.mem_write;
  assign bus.de_reg_write = de_q.reg_write;
  assign bus.de_branch    = de_q.branch;
  assign bus.de_illegal   = de_q.illegal;

endmodule

// File: tb/tb_stage_decode.sv
// tb_stage_decode: directed stimulus for stage_decode with an instruction-
// level reference model compared every cycle, plus literal expectations.
module tb_stage_decode;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  stage_decode_if bus ();

  stage_decode dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  // ---------------- reference model ----------------
  typedef struct {
    bit          valid;
    logic [31:0] next_pc;
    logic [5:0]  op;
    logic [4:0]  rs, rt, dest;
    logic [31:0] rs_data, rt_data, imm;
    bit          mr, mw, rw, br, ill;
  } de_m_t;

  de_m_t       m;
  logic [31:0] m_rf [32];

  function automatic de_m_t zero_de();
    de_m_t z;
    z.valid = 0; z.next_pc = 0; z.op = 0; z.rs = 0; z.rt = 0; z.dest = 0;
    z.rs_data = 0; z.rt_data = 0; z.imm = 0;
    z.mr = 0; z.mw = 0; z.rw = 0; z.br = 0; z.ill = 0;
    return z;
  endfunction

  function automatic logic [31:0] model_read(input logic [4:0] idx);
    if (idx == 0) return 32'd0;
    if (bus.wb_wren && bus.wb_addr == idx) return bus.wb_data;
    return m_rf[idx];
  endfunction

  function automatic bit model_lu();
    logic [31:0] ins;
    ins = bus.in_ins;
    return m.valid && m.mr && m.dest != 0 && bus.in_valid &&
           (m.dest == ins[25:21] || m.dest == ins[20:16]);
  endfunction

  // Instruction semantics straight from the opcode table.
  function automatic de_m_t model_decode();
    de_m_t d;
    logic [31:0] ins;
    ins = bus.in_ins;
    d = zero_de();
    d.valid = bus.in_valid;
    d.next_pc = bus.in_next_pc;
    d.op = ins[31:26];
    d.rs = ins[25:21];
    d.rt = ins[20:16];
    d.rs_data = model_read(ins[25:21]);
    d.rt_data = model_read(ins[20:16]);
    d.imm = 32'(signed'(ins[15:0]));
    if      (d.op == 6'h00) begin d.rw = 1; d.dest = ins[15:11]; end
    else if (d.op == 6'h08) begin d.rw = 1; d.dest = ins[20:16]; end
    else if (d.op == 6'h23) begin d.rw = 1; d.mr = 1; d.dest = ins[20:16]; end
    else if (d.op == 6'h2B) d.mw = 1;
    else if (d.op == 6'h04) d.br = 1;
    else d.ill = 1;
    if (d.dest == 0) d.rw = 0;
    if (!bus.in_valid) begin d.mr = 0; d.mw = 0; d.rw = 0; d.br = 0; d.ill = 0; end
    return d;
  endfunction

  task automatic kill_ctrl();
    m.valid = 0; m.mr = 0; m.mw = 0; m.rw = 0; m.br = 0; m.ill = 0;
  endtask

  always @(posedge clk) begin
    if (reset_n) begin
      if (bus.flush) kill_ctrl();
      else if (bus.de_stall) ;
      else if (model_lu()) kill_ctrl();
      else m = model_decode();
    end
    if (bus.wb_wren && bus.wb_addr != 0) m_rf[bus.wb_addr] = bus.wb_data;
  end

  always @(negedge reset_n) m = zero_de();

  // ---------------- per-cycle scoreboard compare ----------------
  always @(negedge clk) begin
    if (started && reset_n) begin
      bit exp_hold;
      exp_hold = model_lu() || bus.de_stall;
      checks++;
      if (bus.de_valid !== m.valid || bus.de_next_pc !== m.next_pc ||
          bus.de_opcode !== m.op || bus.de_rs !== m.rs || bus.de_rt !== m.rt ||
          bus.de_dest !== m.dest || bus.de_rs_data !== m.rs_data ||
          bus.de_rt_data !== m.rt_data || bus.de_imm !== m.imm ||
          bus.de_mem_read !== m.mr || bus.de_mem_write !== m.mw ||
          bus.de_reg_write !== m.rw || bus.de_branch !== m.br ||
          bus.de_illegal !== m.ill || bus.fd_hold !== exp_hold) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t act v=%0b pc=%h op=%h dest=%0d rsd=%h rtd=%h imm=%h ctl=%b%b%b%b%b hold=%0b exp v=%0b pc=%h op=%h dest=%0d rsd=%h rtd=%h imm=%h ctl=%b%b%b%b%b hold=%0b",
                 $time, bus.de_valid, bus.de_next_pc, bus.de_opcode, bus.de_dest,
                 bus.de_rs_data, bus.de_rt_data, bus.de_imm, bus.de_mem_read,
                 bus.de_mem_write, bus.de_reg_write, bus.de_branch, bus.de_illegal,
                 bus.fd_hold, m.valid, m.next_pc, m.op, m.dest, m.rs_data, m.rt_data,
                 m.imm, m.mr, m.mw, m.rw, m.br, m.ill, exp_hold);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic present(input logic v, input logic [31:0] ins, input logic [31:0] pc);
    bus.in_valid = v;
    bus.in_ins = ins;
    bus.in_next_pc = pc;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    m = zero_de();
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    present(1'b0, 32'd0, 32'd0);
    bus.flush = 0; bus.de_stall = 0;
    bus.wb_wren = 0; bus.wb_addr = 0; bus.wb_data = 0;

    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    started = 1'b1;
    #1;
    chk("rst_valid", 32'(bus.de_valid), 32'd0);
    chk("rst_pc", bus.de_next_pc, 32'd0);
    chk("rst_hold", 32'(bus.fd_hold), 32'd0);

    // Give every register a known value.
    for (int i = 1; i < 32; i++) begin
      bus.wb_wren = 1; bus.wb_addr = 5'(i); bus.wb_data = 32'h1000_0000 | 32'(i);
      cycle();
    end
    bus.wb_wren = 0;

    // ADDI r5, r0, -1
    present(1'b1, 32'h2005FFFF, 32'h0000_0104);
    cycle();
    chk("addi_valid", 32'(bus.de_valid), 32'd1);
    chk("addi_dest", 32'(bus.de_dest), 32'd5);
    chk("addi_imm", bus.de_imm, 32'hFFFF_FFFF);
    chk("addi_rw", 32'(bus.de_reg_write), 32'd1);
    chk("addi_pc", bus.de_next_pc, 32'h0000_0104);
    present(1'b0, 32'd0, 32'd0);
    #1 chk("addi_hold", 32'(bus.fd_hold), 32'd0);

    // Same-cycle writeback to r3 bypassed into an R-type reading rs=3.
    bus.wb_wren = 1; bus.wb_addr = 5'd3; bus.wb_data = 32'h1234_5678;
    present(1'b1, 32'h00643020, 32'h0000_0108);
    cycle();
    chk("byp_rs", bus.de_rs_data, 32'h1234_5678);
    chk("byp_rt", bus.de_rt_data, 32'h1000_0004);
    chk("byp_dest", 32'(bus.de_dest), 32'd6);
    // Writeback to r0 while reading r0, then read r0 again.
    bus.wb_addr = 5'd0; bus.wb_data = 32'hDEAD_BEEF;
    present(1'b1, 32'h00000820, 32'h0000_010C);
    cycle();
    chk("r0_byp", bus.de_rs_data, 32'd0);
    bus.wb_wren = 0;
    cycle();
    chk("r0_read", bus.de_rt_data, 32'd0);
    // R-type with rd=0 never writes.
    present(1'b1, 32'h00000020, 32'h0000_0110);
    cycle();
    chk("rd0_rw", 32'(bus.de_reg_write), 32'd0);
    chk("rd0_valid", 32'(bus.de_valid), 32'd1);

    // LW r7 followed by a dependent R-type (rt=7).
    present(1'b1, 32'h8C270004, 32'h0000_0114);
    cycle();
    chk("lw_mr", 32'(bus.de_mem_read), 32'd1);
    chk("lw_dest", 32'(bus.de_dest), 32'd7);
    present(1'b1, 32'h00474020, 32'h0000_0118);
    #1 chk("lu_hold", 32'(bus.fd_hold), 32'd1);
    cycle();
    chk("lu_bubble", 32'(bus.de_valid), 32'd0);
    #1 chk("lu_hold_drop", 32'(bus.fd_hold), 32'd0);
    cycle();
    chk("lu_accept", 32'(bus.de_valid), 32'd1);
    chk("lu_dest", 32'(bus.de_dest), 32'd8);
    chk("lu_rt", bus.de_rt_data, 32'h1000_0007);

    // ADDI r9, r2, 16 then a 3-cycle de_stall with a SW presented.
    present(1'b1, 32'h20490010, 32'h0000_0200);
    cycle();
    chk("st_load_dest", 32'(bus.de_dest), 32'd9);
    bus.de_stall = 1;
    present(1'b1, 32'hAC220008, 32'h0000_0204);
    for (int k = 0; k < 3; k++) begin
      #1 chk("st_hold", 32'(bus.fd_hold), 32'd1);
      cycle();
      chk("st_dest", 32'(bus.de_dest), 32'd9);
      chk("st_pc", bus.de_next_pc, 32'h0000_0200);
      chk("st_rs", bus.de_rs_data, 32'h1000_0002);
    end
    bus.de_stall = 0;
    cycle();
    chk("st_rel_mw", 32'(bus.de_mem_write), 32'd1);
    chk("st_rel_dest", 32'(bus.de_dest), 32'd0);
    chk("st_rel_imm", bus.de_imm, 32'd8);

    // Flush beats a simultaneous de_stall.
    bus.flush = 1; bus.de_stall = 1;
    present(1'b1, 32'hAC220008, 32'h0000_0208);
    cycle();
    chk("fl_valid", 32'(bus.de_valid), 32'd0);
    chk("fl_mw", 32'(bus.de_mem_write), 32'd0);
    bus.flush = 0; bus.de_stall = 0;

    // Illegal opcode 0x3F (rt field nonzero) then BEQ.
    present(1'b1, 32'hFC0A0000, 32'h0000_0300);
    cycle();
    chk("ill_flag", 32'(bus.de_illegal), 32'd1);
    chk("ill_rw", 32'(bus.de_reg_write), 32'd0);
    chk("ill_dest", 32'(bus.de_dest), 32'd0);
    present(1'b1, 32'h10220003, 32'h0000_0304);
    cycle();
    chk("beq_br", 32'(bus.de_branch), 32'd1);
    chk("beq_ill", 32'(bus.de_illegal), 32'd0);

    // Reset asserted in the middle of a load-use stall.
    present(1'b1, 32'h8C270004, 32'h0000_0400);
    cycle();
    present(1'b1, 32'h00474020, 32'h0000_0404);
    #1 chk("rs_pre_hold", 32'(bus.fd_hold), 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("ar_hold", 32'(bus.fd_hold), 32'd0);
    chk("ar_valid", 32'(bus.de_valid), 32'd0);
    chk("ar_pc", bus.de_next_pc, 32'd0);
    chk("ar_mr", 32'(bus.de_mem_read), 32'd0);
    chk("ar_rtd", bus.de_rt_data, 32'd0);
    chk("ar_imm", bus.de_imm, 32'd0);
    present(1'b0, 32'd0, 32'd0);
    cycle();
    reset_n = 1'b1;
    present(1'b1, 32'h2005FFFF, 32'h0000_0500);
    cycle();
    chk("post_rst_valid", 32'(bus.de_valid), 32'd1);
    present(1'b0, 32'd0, 32'd0);
    cycle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_decode.md
Name: stage_decode

Overview:
- Instruction-decode stage plus D/E pipeline register.
- Sits directly downstream of the fetch/decode stage register and consumes the instruction word and next-PC it holds.
- Owns the 32x32 register file with a writeback port, plus load-use hazard detection.
- Drives a hold request back to control so that PC and the FD register freeze during a stall.

Parameters:
- XLEN, 32, data/address width.
- NREG, 32, register count; register 0 reads as zero.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  FD register holds a valid instruction
- in_ins  in  32  instruction word from FD
- in_next_pc  in  32  PC+4 from FD
- flush  in  1  branch/redirect taken; kill the instruction entering DE
- de_stall  in  1  downstream cannot accept; hold DE contents
- wb_wren  in  1  register-file write enable
- wb_addr  in  5  write register index
- wb_data  in  32  write data
- fd_hold  out  1  request control to deassert pc_wren/fd_wren this cycle
- de_valid  out  1  DE register holds a valid instruction
- de_next_pc  out  32
- de_opcode  out  6  in_ins[31:26]
- de_rs, de_rt  out  5 each
- de_dest  out  5  destination register (0 = none)
- de_rs_data, de_rt_data  out  32  register-file read values
- de_imm  out  32  in_ins[15:0], sign-extended
- de_mem_read, de_mem_write, de_reg_write, de_branch, de_illegal  out  1 each

Behaviour:
- Fields: opcode [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0].
- Decode table:
  - op 0x00 R-type: reg_write, dest=rd.
  - op 0x08 ADDI: reg_write, dest=rt.
  - op 0x23 LW: reg_write, mem_read, dest=rt.
  - op 0x2B SW: mem_write, dest=0.
  - op 0x04 BEQ: branch, dest=0.
  - Any other op: illegal=1, all other controls 0, dest=0.
- reg_write is forced 0 whenever dest==0.
- Register file:
  - Synchronous write on clk when wb_wren and wb_addr!=0.
  - Writes to r0 are ignored.
  - Read is combinational, with write-through bypass: if wb_wren and wb_addr==read index (nonzero), the read returns wb_data in the same cycle.
  - Reads of index 0 return 0.
  - Register contents are not reset.
- Load-use hazard (lu): de_valid & de_mem_read & de_dest!=0 & in_valid & (de_dest==rs | de_dest==rt).
- fd_hold = lu | de_stall (combinational).
- DE register update per rising edge, evaluated in priority order:
  1. flush=1: de_valid<=0, all control outputs <=0; flush overrides de_stall and lu.
  2. de_stall=1: all DE outputs hold their values.
  3. lu=1: insert a bubble (de_valid<=0, controls<=0; data fields don't-care, implemented as hold).
  4. Otherwise: load decoded fields; de_valid<=in_valid; if in_valid=0 all controls <=0.
- A load-use stall lasts exactly one cycle. The next cycle DE holds the bubble, lu drops, and the held FD instruction is accepted.
- Latency: 1 cycle from in_ins to DE outputs.
- Reset (asynchronous, on reset_n low):
  - de_valid, all control bits and de_illegal <=0.
  - de_next_pc, de_opcode, de_rs, de_rt, de_dest, de_imm, de_rs_data, de_rt_data <=0.
  - fd_hold follows its combinational equation (0 after reset since de_valid=0 and de_stall is expected 0).
  - Reset mid-stall aborts the stall immediately.

Test Plan:
- Reset, then ADDI r5,r0,-1 (0x2005FFFF) with in_valid=1 -> next cycle de_valid=1, de_dest=5, de_imm=0xFFFFFFFF, de_reg_write=1, fd_hold=0.
- wb r3=0x12345678 in the same cycle as an R-type reading rs=3 -> de_rs_data=0x12345678 (bypass); wb to r0 then read r0 -> 0.
- LW r7 accepted, then next instruction is an R-type with rt=7 -> fd_hold=1 for exactly one cycle, DE shows de_valid=0 bubble, then the R-type appears with de_valid=1.
- de_stall=1 for 3 cycles with new instructions presented -> DE outputs unchanged, fd_hold=1 throughout; on release the pending instruction loads.
- flush=1 with a valid SW presented and de_stall=1 simultaneously -> de_valid=0, de_mem_write=0 next cycle.
- Opcode 0x3F -> de_illegal=1, de_reg_write=0, de_dest=0; assert reset_n low mid-operation -> all DE outputs 0 immediately, asynchronously.
